// File: rtl/block_checker.sv
// rtl/block_checker.sv - self-synchronising checker for the 257-bit LFSR block stream
//
// Purpose: seeds an expected-block register from the received stream, predicts
// each following block with the generator's 257-step LFSR advance, declares
// lock after LOCK_GOOD consecutive matches and keeps saturating block,
// error-block and bit-error statistics while locked.
//
// Ports:
//   clk                in   rising-edge clock
//   rst                in   asynchronous active-high reset
//   i_data             in   received block (BLOCK_SIZE bits)
//   i_valid            in   i_data valid this cycle, no backpressure
//   i_clear_counters   in   synchronous clear of the three statistics counters
//   o_lock             out  high while locked
//   o_err_flag         out  one-cycle pulse after a mismatching block checked while locked
//   o_block_count      out  blocks checked while locked (saturating)
//   o_err_block_count  out  mismatching blocks while locked (saturating)
//   o_bit_err_count    out  accumulated bit errors while locked (saturating)

module block_checker #(
  parameter int BLOCK_SIZE = 257,
  parameter int LOCK_GOOD  = 4,
  parameter int UNLOCK_BAD = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BLOCK_SIZE-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_clear_counters,
  output logic                  o_lock,
  output logic                  o_err_flag,
  output logic [CNT_W-1:0]      o_block_count,
  output logic [CNT_W-1:0]      o_err_block_count,
  output logic [CNT_W-1:0]      o_bit_err_count
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int PW = $clog2(BLOCK_SIZE + 1);
  // Sum width wide enough that neither operand is truncated before clamping.
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_CHECKING = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BLOCK_SIZE-1:0] expected_q, expected_d;
  logic [GW-1:0]         good_q, good_d, good_inc;
  logic [BW-1:0]         bad_q, bad_d, bad_inc;
  logic [BLOCK_SIZE-1:0] rx_pred, exp_pred, diff;
  logic [PW-1:0]         pop;
  logic                  mismatch, data_nz;
  logic                  count_blk, count_err, err_d;
  logic [SW-1:0]         bit_sum;

  // One generator block step: 257 single-bit LFSR advances. The taps are
  // fixed for the 257-bit polynomial.
  function automatic logic [BLOCK_SIZE-1:0] lfsr_next(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] t;
    logic                  fb;
    t = s;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      fb = t[256] ^ t[255] ^ t[253] ^ t[251];
      t  = {t[BLOCK_SIZE-2:0], fb};
    end
    return t;
  endfunction

  always_comb begin
    rx_pred  = lfsr_next(i_data);
    exp_pred = lfsr_next(expected_q);
    diff     = i_data ^ expected_q;
    mismatch = |diff;
    data_nz  = |i_data;
    pop      = PW'($countones(diff));
    good_inc = good_q + GW'(1);
    bad_inc  = bad_q + BW'(1);
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    bad_d      = bad_q;
    count_blk  = 1'b0;
    count_err  = 1'b0;
    err_d      = 1'b0;
    if (i_valid) begin
      case (state_q)
        S_UNLOCKED: begin
          // An all-zero block is the LFSR lock-up state and cannot seed.
          if (data_nz) begin
            expected_d = rx_pred;
            good_d     = '0;
            state_d    = S_CHECKING;
          end
        end
        S_CHECKING: begin
          if (!mismatch) begin
            expected_d = exp_pred;
            good_d     = good_inc;
            if (good_inc == GW'(LOCK_GOOD)) begin
              state_d = S_LOCKED;
              bad_d   = '0;
            end
          end else if (data_nz) begin
            expected_d = rx_pred;
            good_d     = '0;
          end else begin
            state_d = S_UNLOCKED;
          end
        end
        S_LOCKED: begin
          // Free-run on the prediction so a corrupted block never reseeds.
          expected_d = exp_pred;
          count_blk  = 1'b1;
          if (mismatch) begin
            count_err = 1'b1;
            err_d     = 1'b1;
            bad_d     = bad_inc;
            if (bad_inc == BW'(UNLOCK_BAD)) state_d = S_UNLOCKED;
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end
  end

  always_comb begin
    bit_sum = SW'(o_bit_err_count) + SW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_UNLOCKED;
      expected_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      o_err_flag <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      o_err_flag <= err_d;
    end
  end

  assign o_lock = (state_q == S_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_block_count     <= '0;
      o_err_block_count <= '0;
      o_bit_err_count   <= '0;
    end else if (i_clear_counters) begin
      o_block_count     <= '0;
      o_err_block_count <= '0;
      o_bit_err_count   <= '0;
    end else begin
      if (count_blk && (o_block_count != '1)) o_block_count <= o_block_count + CNT_W'(1);
      if (count_err) begin
        if (o_err_block_count != '1) o_err_block_count <= o_err_block_count + CNT_W'(1);
        o_bit_err_count <= (|bit_sum[SW-1:CNT_W]) ? '1 : bit_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_block_checker.sv
// tb/tb_block_checker.sv - randomized self-checking bench for block_checker

module tb_block_checker;

  localparam int BS = 257;

  logic          clk = 1'b0;
  logic          rst;
  logic [BS-1:0] i_data;
  logic          i_valid;
  logic          i_clear_counters;

  logic          o_lock, o_err_flag;
  logic [31:0]   o_block_count, o_err_block_count, o_bit_err_count;
  logic          n_lock, n_err_flag;
  logic [3:0]    n_block_count, n_err_block_count, n_bit_err_count;

  block_checker dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_clear_counters(i_clear_counters), .o_lock(o_lock), .o_err_flag(o_err_flag),
    .o_block_count(o_block_count), .o_err_block_count(o_err_block_count),
    .o_bit_err_count(o_bit_err_count)
  );

  block_checker #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_clear_counters(i_clear_counters), .o_lock(n_lock), .o_err_flag(n_err_flag),
    .o_block_count(n_block_count), .o_err_block_count(n_err_block_count),
    .o_bit_err_count(n_bit_err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: mode 0/1/2 = unlocked/checking/locked, counters kept as
  // unbounded totals and clamped to the counter width only when compared.
  int          m_mode, m_good, m_bad;
  bit [BS-1:0] m_exp;
  longint      m_blk, m_errb, m_bits;
  bit          m_flag;
  bit [BS-1:0] g;

  function automatic bit [BS-1:0] gen_next(input bit [BS-1:0] s);
    bit fb;
    for (int i = 0; i < BS; i++) begin
      fb = s[256] ^ s[255] ^ s[253] ^ s[251];
      s  = {s[BS-2:0], fb};
    end
    return s;
  endfunction

  function automatic bit [BS-1:0] step_gen();
    g = gen_next(g);
    return g;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_bad = 0; m_exp = '0;
    m_blk = 0; m_errb = 0; m_bits = 0; m_flag = 0;
  endtask

  task automatic model_step(input bit [BS-1:0] d, input bit v, input bit clr);
    int pe;
    m_flag = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_exp = gen_next(d); m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_exp = gen_next(m_exp);
          m_good++;
          if (m_good == 4) begin m_mode = 2; m_bad = 0; end
        end else if (d != 0) begin
          m_exp = gen_next(d); m_good = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        pe = $countones(d ^ m_exp);
        m_exp = gen_next(m_exp);
        m_blk++;
        if (pe > 0) begin
          m_errb++; m_bits += pe; m_flag = 1; m_bad++;
          if (m_bad == 3) m_mode = 0;
        end else begin
          m_bad = 0;
        end
      end
    end
    if (clr) begin m_blk = 0; m_errb = 0; m_bits = 0; end
  endtask

  task automatic compare_all(input string c);
    check({c, ".lock"}, o_lock, m_mode == 2);
    check({c, ".flag"}, o_err_flag, m_flag);
    check({c, ".blk"}, o_block_count, sat(m_blk, 32));
    check({c, ".errb"}, o_err_block_count, sat(m_errb, 32));
    check({c, ".bits"}, o_bit_err_count, sat(m_bits, 32));
    check({c, ".n_lock"}, n_lock, m_mode == 2);
    check({c, ".n_flag"}, n_err_flag, m_flag);
    check({c, ".n_blk"}, n_block_count, sat(m_blk, 4));
    check({c, ".n_errb"}, n_err_block_count, sat(m_errb, 4));
    check({c, ".n_bits"}, n_bit_err_count, sat(m_bits, 4));
  endtask

  task automatic drive(input string c, input bit [BS-1:0] d, input bit v, input bit clr);
    @(negedge clk);
    i_data = d; i_valid = v; i_clear_counters = clr;
    @(posedge clk);
    model_step(d, v, clr);
    #1;
    compare_all(c);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_seed();
    for (int i = 0; i < BS; i++) g[i] = 1'($urandom_range(0, 1));
    g[0] = 1'b1;
  endtask

  bit [BS-1:0] d;
  bit          v, c;

  initial begin
    rst = 1'b1; i_data = '0; i_valid = 1'b0; i_clear_counters = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Clean stream: lock after the fifth block, then 15 locked blocks.
    new_seed();
    for (int k = 1; k <= 20; k++) begin
      d = (k == 1) ? g : step_gen();
      drive("t1", d, 1, 0);
      if (k == 4) check("t1.lock_b4", o_lock, 0);
      if (k == 5) check("t1.lock_b5", o_lock, 1);
    end
    check("t1.blk15", o_block_count, 15);
    check("t1.errb0", o_err_block_count, 0);

    // Single bit error while locked.
    for (int k = 1; k <= 10; k++) begin
      d = step_gen();
      if (k == 5) d[0] = ~d[0];
      drive("t2", d, 1, 0);
      if (k == 5) check("t2.flag", o_err_flag, 1);
      if (k == 6) check("t2.flag_off", o_err_flag, 0);
    end
    check("t2.errb", o_err_block_count, 1);
    check("t2.bits", o_bit_err_count, 1);
    check("t2.lock", o_lock, 1);

    // Three consecutive 2-bit errors drop lock; relock after reseed + 4.
    for (int k = 1; k <= 3; k++) begin
      d = step_gen();
      d[3] = ~d[3]; d[100] = ~d[100];
      drive("t3", d, 1, 0);
    end
    check("t3.unlock", o_lock, 0);
    check("t3.errb", o_err_block_count, 4);
    check("t3.bits", o_bit_err_count, 7);
    for (int k = 1; k <= 5; k++) begin
      drive("t3r", step_gen(), 1, 0);
      if (k == 4) check("t3.lock_k4", o_lock, 0);
      if (k == 5) check("t3.lock_k5", o_lock, 1);
    end

    // Idle gap with garbage data leaves state untouched.
    drive("t4", step_gen(), 1, 0);
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < BS; i++) d[i] = 1'($urandom_range(0, 1));
      drive("t4i", d, 0, 0);
    end
    drive("t4", step_gen(), 1, 0);
    check("t4.noflag", o_err_flag, 0);
    check("t4.errb", o_err_block_count, 4);

    // Zero blocks never seed; a corrupted B3 delays lock.
    apply_reset();
    for (int k = 0; k < 10; k++) drive("t5z", '0, 1, 0);
    check("t5.zlock", o_lock, 0);
    check("t5.zblk", o_block_count, 0);
    new_seed();
    for (int k = 1; k <= 10; k++) begin
      d = (k == 1) ? g : step_gen();
      if (k == 3) d[17] = ~d[17];
      drive("t5", d, 1, 0);
      if (k == 7) check("t5.lock_b7", o_lock, 0);
      if (k == 8) check("t5.lock_b8", o_lock, 1);
    end

    // Asynchronous reset mid-lock, observed without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("t6rst");
    check("t6.rst_lock", o_lock, 0);
    check("t6.rst_blk", o_block_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clear coincident with an error block: clear wins, flag still pulses.
    new_seed();
    for (int k = 1; k <= 7; k++) drive("t6", (k == 1) ? g : step_gen(), 1, 0);
    d = step_gen();
    d[200] = ~d[200];
    drive("t6c", d, 1, 1);
    check("t6.clr_blk", o_block_count, 0);
    check("t6.clr_errb", o_err_block_count, 0);
    check("t6.clr_flag", o_err_flag, 1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      d = v ? step_gen() : '0;
      if (v && $urandom_range(0, 7) == 0) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) begin
          int b;
          b = $urandom_range(0, BS - 1);
          d[b] = ~d[b];
        end
      end
      if (v && $urandom_range(0, 59) == 0) d = '0;
      drive("rnd", d, v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
